pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and fetches one instruction per decode cycle from a handshaked instruction memory.
- Presents opcode/funct fields to the decoder, then applies the decoder's muxPC select to form the next PC: sequential, jump, jump-register or taken branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width. Fixed at 32; the jump-target math assumes 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  word-aligned fetch address; equals pc.
- imem_ready  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction register (IR).
- instr_valid  output  1  IR holds an instruction awaiting decode/execute.
- instr_ack  input  1  execute complete; muxPC and jr_target valid this cycle.
- muxPC  input  2  next-PC select from decoder: 0 = PC+4, 1 = jump, 2 = jr, 3 = branch.
- jr_target  input  32  rs register value for jr.
- pc  output  32  address of the instruction in IR.
- pc_plus4  output  32  pc+4, for the JAL link path.
- opcode  output  6  instr[31:26].
- functcode  output  6  instr[5:0].
- align_fault  output  1  misaligned next-PC trap (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): state=START, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, align_fault=0.
- Any in-flight fetch is abandoned. imem_rdata is ignored until a new request is issued.
- States:
  - START: imem_req=0. Always goes to FETCH next cycle, so the first request is in the 2nd cycle after rst_n rises.
  - FETCH: imem_req=1, imem_addr=pc. When imem_ready=1: IR<=imem_rdata, instr_valid<=1, go to HOLD. Otherwise stay in FETCH with the request held steady.
  - HOLD: imem_req=0, instr_valid=1, IR stable. When instr_ack=1: pc<=next_pc, instr_valid<=0, go to FETCH.
  - FAULT: only when ALIGN_CHECK_EN is defined.
- Minimum throughput is one instruction per 2 cycles (imem_ready in the first FETCH cycle, instr_ack in the first HOLD cycle).
- instr_ack outside HOLD is ignored.
- muxPC and jr_target are sampled only in the HOLD cycle that has instr_ack=1.
- next_pc (all arithmetic modulo 2^32, wrap with no flag):
  - 0: pc_plus4.
  - 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 2: jr_target.
  - 3: pc_plus4 + (sign_extend(instr[15:0]) << 2).
- Combinational outputs:
  - pc_plus4 = pc + 4; pc=32'hFFFF_FFFC gives 32'h0.
  - opcode and functcode are driven directly from IR.
- imem_ready while not in FETCH is ignored.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined: in the instr_ack cycle, if next_pc[1:0]!=0 (reachable only via jr):
  - pc is not updated, and the state goes to FAULT.
  - align_fault<=1 and stays high; instr_valid<=0; imem_req=0.
  - FAULT is left only by reset.
- Undefined: next_pc[1:0] is forced to 2'b00, align_fault is tied to 0, and no FAULT state exists.

Test Plan:
- Reset release, RESET_PC=0, memory returns imem_ready on the first request -> imem_req rises in the 2nd cycle after rst_n rises with imem_addr=0. The next cycle shows instr_valid=1, IR=imem_rdata, opcode/functcode equal to its fields.
- Sequential: pc=0x100, ack with muxPC=0 -> next request addr=0x104. pc=0xFFFF_FFFC with muxPC=0 -> addr wraps to 0x0.
- Jump and branch, pc=0x1000_0040:
  - instr=0x0800_0010, muxPC=1 -> pc=0x1000_0040.
  - instr imm=0xFFFE, muxPC=3 -> pc=0x1000_003C.
  - imm=0x0003, muxPC=3 -> pc=0x1000_0050.
- jr: jr_target=0x0000_2000, muxPC=2 -> pc=0x2000. jr_target=0x2002 -> with ALIGN_CHECK_EN, align_fault=1, pc unchanged, no further imem_req; without it, pc=0x2000.
- Backpressure: imem_ready held low 5 cycles -> imem_req and imem_addr stable, instr_valid=0. instr_ack held low 4 cycles in HOLD -> IR, pc and instr_valid stable; muxPC changes during the wait have no effect.
- Reset mid-operation: assert rst_n low during FETCH with imem_ready=1 in that same cycle -> IR stays 0, pc=RESET_PC, instr_valid=0, align_fault cleared.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch stage ahead of the instruction decoder.
// Holds the PC, fetches one word per decode from a handshaked memory,
// presents opcode/funct to the decoder and forms the next PC from muxPC.
//
// Optional feature macro: ALIGN_CHECK_EN (misaligned next-PC trap).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req, imem_addr        fetch request / word address (= pc)
//   imem_ready, imem_rdata     memory data-valid strobe / instruction word
//   instr, instr_valid         instruction register and its valid flag
//   instr_ack                  execute done; muxPC / jr_target valid
//   muxPC, jr_target           next-PC select (0 seq, 1 j, 2 jr, 3 br), jr value
//   pc, pc_plus4               address of instr, and pc+4 (link path)
//   opcode, functcode          instr[31:26], instr[5:0]
//   align_fault                sticky misaligned-target trap
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic [1:0]        muxPC,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [5:0]        opcode,
    output logic [5:0]        functcode,
    output logic              align_fault
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
`ifdef ALIGN_CHECK_EN
        , ST_FAULT = 2'd3
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic              r_req;
    logic              w_ir_load;
    logic              w_pc_load;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_next_pc_raw;
    logic [ADDR_W-1:0] w_next_pc;

    // Next-PC candidates; all arithmetic wraps modulo 2^32
    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_next_pc_raw = w_pc_plus4;
        case (muxPC)
            2'd0:    w_next_pc_raw = w_pc_plus4;
            2'd1:    w_next_pc_raw = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            2'd2:    w_next_pc_raw = jr_target;
            default: w_next_pc_raw = w_pc_plus4 + w_br_off;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    logic w_misalign;
    logic w_fault_set;
    logic r_fault;

    assign w_next_pc  = w_next_pc_raw;
    assign w_misalign = |w_next_pc_raw[1:0];
`else
    // Without the trap, low address bits are simply dropped
    assign w_next_pc  = w_next_pc_raw & ~ADDR_W'(3);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_START;
        else        r_state <= w_state_nxt;
    end

    // Next-state and load enables
    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
`ifdef ALIGN_CHECK_EN
        w_fault_set = 1'b0;
`endif
        case (r_state)
            ST_START: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
`ifdef ALIGN_CHECK_EN
                    if (w_misalign) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_load   = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
`else
                    w_pc_load   = 1'b1;
                    w_state_nxt = ST_FETCH;
`endif
                end
            end
            // FAULT is sticky until reset
            default: w_state_nxt = r_state;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_req   <= (w_state_nxt == ST_FETCH);
            r_valid <= (w_state_nxt == ST_HOLD);
            if (w_ir_load) r_instr <= imem_rdata;
            if (w_pc_load) r_pc    <= w_next_pc;
        end
    end

`ifdef ALIGN_CHECK_EN
    // Sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_fault <= 1'b0;
        else if (w_fault_set) r_fault <= 1'b1;
    end
    assign align_fault = r_fault;
`else
    assign align_fault = 1'b0;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign opcode      = r_instr[31:26];
    assign functcode   = r_instr[5:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// fetch/execute loop checked against a transaction-level PC model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [1:0]  muxPC;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  functcode;
    logic        align_fault;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    bit          flt;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .muxPC       (muxPC),
        .jr_target   (jr_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .opcode      (opcode),
        .functcode   (functcode),
        .align_fault (align_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; stimulus and sampling happen at the falling edge
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Architectural next-PC rule
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ir,
                                               input int sel, input logic [31:0] jr);
        logic [31:0]       seq;
        logic signed [15:0] imm;
        seq = cur_pc + 32'd4;
        imm = ir[15:0];
        case (sel)
            0:       return seq;
            1:       return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
            2:       return jr;
            default: return seq + 32'(int'(imm) * 4);
        endcase
    endfunction

    task automatic check_hold(input string tag);
        check({tag, "/pc"},    pc,          exp_pc);
        check({tag, "/ir"},    instr,       exp_ir);
        check({tag, "/vld"},   32'(instr_valid), 32'd1);
        check({tag, "/req"},   32'(imem_req),    32'd0);
        check({tag, "/op"},    32'(opcode),      exp_ir / 32'h0400_0000);
        check({tag, "/fn"},    32'(functcode),   exp_ir % 32'd64);
        check({tag, "/pc4"},   pc_plus4,    exp_pc + 32'd4);
        check({tag, "/flt"},   32'(align_fault), 32'd0);
    endtask

    // Reset (may be entered mid-fetch with imem_ready already driven)
    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        imem_ready = 1'b0;
        tick;
        exp_pc = RST_PC;
        exp_ir = 32'h0;
        check("rst/pc",  pc,               RST_PC);
        check("rst/ir",  instr,            32'h0);
        check("rst/vld", 32'(instr_valid), 32'd0);
        check("rst/req", 32'(imem_req),    32'd0);
        check("rst/flt", 32'(align_fault), 32'd0);
        rst_n      = 1'b1;
        imem_ready = 1'($urandom);
        instr_ack  = 1'($urandom);
        check("start/req", 32'(imem_req), 32'd0);
        tick;
    endtask

    // Fetch with 'delay' cycles of memory backpressure before the data
    task automatic do_fetch(input int delay, input logic [31:0] word);
        for (int i = 0; i <= delay; i++) begin
            imem_ready = (i == delay);
            imem_rdata = (i == delay) ? word : $urandom;
            instr_ack  = 1'($urandom);
            muxPC      = 2'($urandom);
            check("fetch/req",  32'(imem_req),    32'd1);
            check("fetch/addr", imem_addr,        exp_pc);
            check("fetch/vld",  32'(instr_valid), 32'd0);
            check("fetch/ir",   instr,            exp_ir);
            tick;
        end
        imem_ready = 1'b0;
        instr_ack  = 1'b0;
        exp_ir     = word;
    endtask

    // Hold for 'waitc' cycles, then acknowledge with the given select
    task automatic do_exec(input int waitc, input int sel, input logic [31:0] jr, output bit faulted);
        logic [31:0] nxt;
        for (int i = 0; i < waitc; i++) begin
            instr_ack  = 1'b0;
            muxPC      = 2'($urandom);
            jr_target  = $urandom;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            check_hold("wait");
            tick;
        end
        instr_ack  = 1'b1;
        muxPC      = 2'(sel);
        jr_target  = jr;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        check_hold("ack");
        tick;
        instr_ack  = 1'b0;
        imem_ready = 1'b0;
        nxt        = model_next(exp_pc, exp_ir, sel, jr);
        faulted    = 1'b0;
`ifdef ALIGN_CHECK_EN
        if (nxt[1:0] != 2'b00) faulted = 1'b1;
        else                   exp_pc  = nxt;
`else
        exp_pc = nxt & 32'hFFFF_FFFC;
`endif
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        instr_ack  = 1'b0;
        muxPC      = 2'd0;
        jr_target  = 32'h0;
        exp_pc     = RST_PC;
        exp_ir     = 32'h0;
        @(negedge clk);

        // Reset release and first fetch answered immediately
        do_reset();
        do_fetch(0, 32'h8C22_0005);
        do_exec(0, 2, 32'h0000_0100, flt);

        // Sequential, then wrap at the top of the address space
        do_fetch(0, $urandom);
        do_exec(0, 0, 32'h0, flt);
        do_fetch(1, $urandom);
        do_exec(0, 2, 32'hFFFF_FFFC, flt);
        do_fetch(0, $urandom);
        do_exec(0, 0, 32'h0, flt);

        // Jump and branches around 0x1000_0040
        do_fetch(0, $urandom);
        do_exec(0, 2, 32'h1000_0040, flt);
        do_fetch(0, 32'h0800_0010);
        do_exec(0, 1, 32'h0, flt);
        do_fetch(0, 32'h1000_FFFE);
        do_exec(0, 3, 32'h0, flt);
        do_fetch(0, 32'h0800_0010);
        do_exec(0, 1, 32'h0, flt);
        do_fetch(0, 32'h1000_0003);
        do_exec(0, 3, 32'h0, flt);

        // jr, then backpressure on both handshakes
        do_fetch(0, $urandom);
        do_exec(0, 2, 32'h0000_2000, flt);
        do_fetch(5, $urandom);
        do_exec(4, 0, 32'h0, flt);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] jr;
            jr = $urandom;
`ifdef ALIGN_CHECK_EN
            jr = jr & 32'hFFFF_FFFC;
`endif
            do_fetch(int'($urandom_range(0, 3)), $urandom);
            do_exec(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), jr, flt);
            check("rand/nofault", 32'(flt), 32'd0);
        end

        // Misaligned jr target
        do_fetch(0, $urandom);
        do_exec(0, 2, 32'h0000_2000, flt);
        do_fetch(0, $urandom);
        do_exec(1, 2, 32'h0000_2002, flt);
`ifdef ALIGN_CHECK_EN
        check("misalign/flag", 32'(flt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'($urandom);
            instr_ack  = 1'($urandom);
            check("fault/flt", 32'(align_fault), 32'd1);
            check("fault/req", 32'(imem_req),    32'd0);
            check("fault/vld", 32'(instr_valid), 32'd0);
            check("fault/pc",  pc,               exp_pc);
            tick;
        end
        instr_ack = 1'b0;
        do_reset();
`else
        check("misalign/flag", 32'(flt), 32'd0);
        check("misalign/pc",   exp_pc,   32'h0000_2000);
`endif

        // Reset asserted in a FETCH cycle that also has imem_ready
        do_fetch(0, $urandom);
        do_exec(0, 0, 32'h0, flt);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        do_reset();
        do_fetch(2, $urandom);
        do_exec(1, 0, 32'h0, flt);
        do_fetch(0, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
